fwd_hazard_ctrl: RTL and testbench

//  Forwarding and load-use hazard controller for the 5-stage MIPS pipeline.

---
 rtl/fwd_hazard_ctrl_if.sv | 37 +++
 rtl/fwd_hazard_ctrl.sv | 141 ++++++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fwd_hazard_ctrl_if.sv
// Bus between the ID-stage decode and the forwarding/hazard controller.
// The master drives the ID-stage fields and flush; the slave returns the mux
// selects, the stall/bubble controls and the stall counter.
interface fwd_hazard_ctrl_if #(
   parameter int unsigned REG_AW = 5,
   parameter int unsigned CNT_W  = 16
);

   logic              id_valid;
   logic [REG_AW-1:0] id_rs;
   logic [REG_AW-1:0] id_rt;
   logic              id_uses_rs;
   logic              id_uses_rt;
   logic [REG_AW-1:0] id_rd;
   logic              id_regwrite;
   logic              id_memread;
   logic              flush;

   logic [1:0]        fwd_a_sel;
   logic [1:0]        fwd_b_sel;
   logic              stall;
   logic              bubble;
   logic [CNT_W-1:0]  stall_count;

   modport master (
      output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
             id_rd, id_regwrite, id_memread, flush,
      input  fwd_a_sel, fwd_b_sel, stall, bubble, stall_count
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
             id_rd, id_regwrite, id_memread, flush,
      output fwd_a_sel, fwd_b_sel, stall, bubble, stall_count
   );

endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller for the 5-stage MIPS pipeline.
// Keeps a tag pipeline (EX/MEM/WB) of destination registers and derives the
// ALU-operand forwarding selects plus the one-cycle load-use stall/bubble.
module fwd_hazard_ctrl #(
   parameter int unsigned REG_AW = 5,
   parameter int unsigned CNT_W  = 16
) (
   input  logic             Clk,
   input  logic             Rst_n,
   fwd_hazard_ctrl_if.slave bus
);

   // Full tag for the instruction in EX; it still needs its source fields.
   typedef struct packed {
      logic              valid;
      logic              regwrite;
      logic              memread;
      logic [REG_AW-1:0] rd;
      logic [REG_AW-1:0] rs;
      logic [REG_AW-1:0] rt;
      logic              uses_rs;
      logic              uses_rt;
   } ex_slot_t;

   // Past EX only the producer side of the tag matters.
   typedef struct packed {
      logic              valid;
      logic              regwrite;
      logic              memread;
      logic [REG_AW-1:0] rd;
   } mem_slot_t;

   typedef struct packed {
      logic              valid;
      logic              regwrite;
      logic [REG_AW-1:0] rd;
   } wb_slot_t;

   ex_slot_t         r_ex;
   mem_slot_t        r_mem;
   wb_slot_t         r_wb;
   logic [CNT_W-1:0] r_stall_count;

   ex_slot_t         w_ex_next;
   logic             w_hz;
   logic             w_mem_fwd_ok;
   logic             w_wb_fwd_ok;
   logic [1:0]       w_fwd_a_sel;
   logic [1:0]       w_fwd_b_sel;

   // Select for one ALU operand; the younger producer in MEM wins over WB.
   function automatic logic [1:0] fwd_sel(
      input logic              ex_valid,
      input logic              uses,
      input logic [REG_AW-1:0] src,
      input logic              mem_ok,
      input logic [REG_AW-1:0] mem_rd,
      input logic              wb_ok,
      input logic [REG_AW-1:0] wb_rd
   );
      logic [1:0] sel;
      sel = 2'b00;
      if (ex_valid && uses) begin
         if (mem_ok && (mem_rd == src)) begin
            sel = 2'b10;
         end else if (wb_ok && (wb_rd == src)) begin
            sel = 2'b01;
         end
      end
      return sel;
   endfunction

   // Load-use detection: a load in EX feeding a source of the ID instruction.
   always_comb begin
      w_hz = 1'b0;
      if (bus.id_valid && !bus.flush && r_ex.valid && r_ex.memread &&
          r_ex.regwrite && (r_ex.rd != '0)) begin
         w_hz = (bus.id_uses_rs && (bus.id_rs == r_ex.rd)) ||
                (bus.id_uses_rt && (bus.id_rt == r_ex.rd));
      end
   end

   // Next EX slot: ID fields when the instruction advances, otherwise a bubble.
   always_comb begin
      w_ex_next = '0;
      if (bus.id_valid && !w_hz && !bus.flush) begin
         w_ex_next.valid    = 1'b1;
         w_ex_next.regwrite = bus.id_regwrite;
         w_ex_next.memread  = bus.id_memread;
         w_ex_next.rd       = bus.id_rd;
         w_ex_next.rs       = bus.id_rs;
         w_ex_next.rt       = bus.id_rt;
         w_ex_next.uses_rs  = bus.id_uses_rs;
         w_ex_next.uses_rt  = bus.id_uses_rt;
      end
   end

   // Forward selects from registered slots only; loads in MEM and $0 never forward.
   always_comb begin
      w_mem_fwd_ok = r_mem.valid && r_mem.regwrite && !r_mem.memread && (r_mem.rd != '0);
      w_wb_fwd_ok  = r_wb.valid && r_wb.regwrite && (r_wb.rd != '0);
      w_fwd_a_sel  = fwd_sel(r_ex.valid, r_ex.uses_rs, r_ex.rs,
                             w_mem_fwd_ok, r_mem.rd, w_wb_fwd_ok, r_wb.rd);
      w_fwd_b_sel  = fwd_sel(r_ex.valid, r_ex.uses_rt, r_ex.rt,
                             w_mem_fwd_ok, r_mem.rd, w_wb_fwd_ok, r_wb.rd);
   end

   // Tag pipeline advances every cycle; it has no hold.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_ex  <= '0;
         r_mem <= '0;
         r_wb  <= '0;
      end else begin
         r_ex           <= w_ex_next;
         r_mem.valid    <= r_ex.valid;
         r_mem.regwrite <= r_ex.regwrite;
         r_mem.memread  <= r_ex.memread;
         r_mem.rd       <= r_ex.rd;
         r_wb.valid     <= r_mem.valid;
         r_wb.regwrite  <= r_mem.regwrite;
         r_wb.rd        <= r_mem.rd;
      end
   end

   // Saturating count of load-use stall cycles.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_stall_count <= '0;
      end else if (w_hz && (r_stall_count != '1)) begin
         r_stall_count <= r_stall_count + CNT_W'(1);
      end
   end

   assign bus.stall       = w_hz;
   assign bus.bubble      = w_hz | bus.flush;
   assign bus.fwd_a_sel   = w_fwd_a_sel;
   assign bus.fwd_b_sel   = w_fwd_b_sel;
   assign bus.stall_count = r_stall_count;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: forwarding paths, load-use stall,
// flush priority, $0 handling, counter saturation and asynchronous reset.
// A second instance with a 4-bit counter exercises saturation quickly.
module tb_fwd_hazard_ctrl;

   logic Clk = 1'b0;
   logic Rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 Clk = ~Clk;

   fwd_hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) bus16 ();
   fwd_hazard_ctrl_if #(.REG_AW(5), .CNT_W(4))  bus4 ();

   fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(16)) dut16 (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .bus   (bus16)
   );

   fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(4)) dut4 (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .bus   (bus4)
   );

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   // Drive the ID stage of the 16-bit-counter instance.
   task automatic drv(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urs, input logic urt, input logic [4:0] rd,
                      input logic rw, input logic mr, input logic fl);
      bus16.id_valid    = v;
      bus16.id_rs       = rs;
      bus16.id_rt       = rt;
      bus16.id_uses_rs  = urs;
      bus16.id_uses_rt  = urt;
      bus16.id_rd       = rd;
      bus16.id_regwrite = rw;
      bus16.id_memread  = mr;
      bus16.flush       = fl;
   endtask

   // Drive the 4-bit instance: either idle or lw $8,0($8).
   task automatic drv4(input logic lw_self);
      bus4.id_valid    = lw_self;
      bus4.id_rs       = lw_self ? 5'd8 : 5'd0;
      bus4.id_rt       = 5'd0;
      bus4.id_uses_rs  = lw_self;
      bus4.id_uses_rt  = 1'b0;
      bus4.id_rd       = lw_self ? 5'd8 : 5'd0;
      bus4.id_regwrite = lw_self;
      bus4.id_memread  = lw_self;
      bus4.flush       = 1'b0;
   endtask

   task automatic drain();
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) step();
   endtask

   task automatic test_reset();
      Rst_n = 1'b0;
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      drv4(1'b0);
      #12;
      n_checks++;
      if (bus16.fwd_a_sel !== 2'b00 || bus16.fwd_b_sel !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_sel got a=%b b=%b exp a=00 b=00", bus16.fwd_a_sel, bus16.fwd_b_sel);
      end
      n_checks++;
      if (bus16.stall !== 1'b0 || bus16.bubble !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_stall got stall=%b bubble=%b exp 0 0", bus16.stall, bus16.bubble);
      end
      n_checks++;
      if (bus16.stall_count !== 16'd0 || bus4.stall_count !== 4'd0) begin
         n_fail++;
         $display("FAIL reset_count got %0d/%0d exp 0/0", bus16.stall_count, bus4.stall_count);
      end
      Rst_n = 1'b1;
      step();
   endtask

   // add $3,$1,$2 ; sub $4,$3,$5
   task automatic test_ex_mem_fwd();
      drv(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0);
      #1;
      n_checks++;
      if (bus16.stall !== 1'b0) begin
         n_fail++;
         $display("FAIL t1_stall_add got %b exp 0", bus16.stall);
      end
      step();
      drv(1, 5'd3, 5'd5, 1, 1, 5'd4, 1, 0, 0);
      #1;
      n_checks++;
      if (bus16.stall !== 1'b0) begin
         n_fail++;
         $display("FAIL t1_stall_sub got %b exp 0", bus16.stall);
      end
      step();
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      n_checks++;
      if (bus16.fwd_a_sel !== 2'b10 || bus16.fwd_b_sel !== 2'b00) begin
         n_fail++;
         $display("FAIL t1_sel got a=%b b=%b exp a=10 b=00", bus16.fwd_a_sel, bus16.fwd_b_sel);
      end
      drain();
   endtask

   // add $3 ; nop ; or $6,$7,$3  then  add $3 ; add $3 ; or $6,$3,$3
   task automatic test_wb_fwd_and_priority();
      drv(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0);
      step();
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
      drv(1, 5'd7, 5'd3, 1, 1, 5'd6, 1, 0, 0);
      step();
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      n_checks++;
      if (bus16.fwd_a_sel !== 2'b00 || bus16.fwd_b_sel !== 2'b01) begin
         n_fail++;
         $display("FAIL t2_wb_sel got a=%b b=%b exp a=00 b=01", bus16.fwd_a_sel, bus16.fwd_b_sel);
      end
      drain();
      drv(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0);
      step();
      drv(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0);
      step();
      drv(1, 5'd3, 5'd3, 1, 1, 5'd6, 1, 0, 0);
      step();
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      n_checks++;
      if (bus16.fwd_a_sel !== 2'b10 || bus16.fwd_b_sel !== 2'b10) begin
         n_fail++;
         $display("FAIL t2_prio_sel got a=%b b=%b exp a=10 b=10", bus16.fwd_a_sel, bus16.fwd_b_sel);
      end
      drain();
   endtask

   // lw $8,0($9) ; add $10,$8,$8
   task automatic test_load_use();
      drv(1, 5'd9, 5'd0, 1, 0, 5'd8, 1, 1, 0);
      step();
      drv(1, 5'd8, 5'd8, 1, 1, 5'd10, 1, 0, 0);
      #1;
      n_checks++;
      if (bus16.stall !== 1'b1 || bus16.bubble !== 1'b1) begin
         n_fail++;
         $display("FAIL t3_stall_on got stall=%b bubble=%b exp 1 1", bus16.stall, bus16.bubble);
      end
      n_checks++;
      if (bus16.stall_count !== 16'd0) begin
         n_fail++;
         $display("FAIL t3_count_before got %0d exp 0", bus16.stall_count);
      end
      step();
      #1;
      n_checks++;
      if (bus16.stall !== 1'b0 || bus16.bubble !== 1'b0) begin
         n_fail++;
         $display("FAIL t3_stall_off got stall=%b bubble=%b exp 0 0", bus16.stall, bus16.bubble);
      end
      n_checks++;
      if (bus16.stall_count !== 16'd1) begin
         n_fail++;
         $display("FAIL t3_count_after got %0d exp 1", bus16.stall_count);
      end
      step();
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      n_checks++;
      if (bus16.fwd_a_sel !== 2'b01 || bus16.fwd_b_sel !== 2'b01) begin
         n_fail++;
         $display("FAIL t3_sel got a=%b b=%b exp a=01 b=01", bus16.fwd_a_sel, bus16.fwd_b_sel);
      end
      drain();
   endtask

   // Writes to $0 are never forwarded; flush beats a load-use hazard.
   task automatic test_zero_and_flush();
      drv(1, 5'd1, 5'd0, 1, 0, 5'd0, 1, 0, 0);
      step();
      drv(1, 5'd0, 5'd0, 1, 1, 5'd5, 1, 0, 0);
      step();
      drv(1, 5'd0, 5'd0, 1, 1, 5'd6, 1, 0, 0);
      n_checks++;
      if (bus16.fwd_a_sel !== 2'b00 || bus16.fwd_b_sel !== 2'b00) begin
         n_fail++;
         $display("FAIL t4_zero_mem got a=%b b=%b exp a=00 b=00", bus16.fwd_a_sel, bus16.fwd_b_sel);
      end
      step();
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      n_checks++;
      if (bus16.fwd_a_sel !== 2'b00 || bus16.fwd_b_sel !== 2'b00) begin
         n_fail++;
         $display("FAIL t4_zero_wb got a=%b b=%b exp a=00 b=00", bus16.fwd_a_sel, bus16.fwd_b_sel);
      end
      drain();
      drv(1, 5'd9, 5'd0, 1, 0, 5'd8, 1, 1, 0);
      step();
      drv(1, 5'd8, 5'd8, 1, 1, 5'd10, 1, 0, 1);
      #1;
      n_checks++;
      if (bus16.stall !== 1'b0 || bus16.bubble !== 1'b1) begin
         n_fail++;
         $display("FAIL t4_flush got stall=%b bubble=%b exp 0 1", bus16.stall, bus16.bubble);
      end
      step();
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      n_checks++;
      if (bus16.stall_count !== 16'd1) begin
         n_fail++;
         $display("FAIL t4_flush_count got %0d exp 1", bus16.stall_count);
      end
      n_checks++;
      if (bus16.fwd_a_sel !== 2'b00 || bus16.fwd_b_sel !== 2'b00) begin
         n_fail++;
         $display("FAIL t4_flush_sel got a=%b b=%b exp a=00 b=00", bus16.fwd_a_sel, bus16.fwd_b_sel);
      end
      drain();
   endtask

   // lw $8,0($8) held in ID stalls every second cycle: 19 stalls into a 4-bit counter.
   task automatic test_saturation();
      logic exp_stall;
      drv4(1'b1);
      for (int i = 0; i < 39; i++) begin
         #1;
         exp_stall = ((i % 2) == 1);
         n_checks++;
         if (bus4.stall !== exp_stall) begin
            n_fail++;
            $display("FAIL t5_sat_stall[%0d] got %b exp %b", i, bus4.stall, exp_stall);
         end
         step();
      end
      drv4(1'b0);
      step();
      n_checks++;
      if (bus4.stall_count !== 4'hF) begin
         n_fail++;
         $display("FAIL t5_sat_count got %h exp f", bus4.stall_count);
      end
   endtask

   // Reset asserted mid-stall clears everything without a clock edge.
   task automatic test_reset_mid_stall();
      drv(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0);
      step();
      drv(1, 5'd3, 5'd0, 1, 0, 5'd8, 1, 1, 0);
      step();
      drv(1, 5'd8, 5'd8, 1, 1, 5'd10, 1, 0, 0);
      #1;
      n_checks++;
      if (bus16.stall !== 1'b1 || bus16.fwd_a_sel !== 2'b10 || bus16.stall_count !== 16'd1) begin
         n_fail++;
         $display("FAIL t5_pre_reset got stall=%b a=%b cnt=%0d exp 1 10 1",
                  bus16.stall, bus16.fwd_a_sel, bus16.stall_count);
      end
      #2;
      Rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus16.stall !== 1'b0 || bus16.bubble !== 1'b0) begin
         n_fail++;
         $display("FAIL t5_rst_stall got stall=%b bubble=%b exp 0 0", bus16.stall, bus16.bubble);
      end
      n_checks++;
      if (bus16.fwd_a_sel !== 2'b00 || bus16.fwd_b_sel !== 2'b00) begin
         n_fail++;
         $display("FAIL t5_rst_sel got a=%b b=%b exp a=00 b=00", bus16.fwd_a_sel, bus16.fwd_b_sel);
      end
      n_checks++;
      if (bus16.stall_count !== 16'd0 || bus4.stall_count !== 4'd0) begin
         n_fail++;
         $display("FAIL t5_rst_count got %0d/%0d exp 0/0", bus16.stall_count, bus4.stall_count);
      end
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      Rst_n = 1'b1;
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_ex_mem_fwd();
      test_wb_fwd_and_priority();
      test_load_use();
      test_zero_and_flush();
      test_saturation();
      test_reset_mid_stall();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
